// File: rtl/fwd_hazard_unit.sv
// Operand bypass select, load-use and multiplier hazard detection,
// single-slot multiplier scoreboard and saturating stall counter.
module fwd_hazard_unit #(
   parameter int REG_AW  = 5,
   parameter int NUM_SRC = 2,
   parameter int MUL_LAT = 3,
   parameter int CNT_W   = 16
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [NUM_SRC*REG_AW-1:0] src_DX,
   input  logic [NUM_SRC*REG_AW-1:0] src_FD,
   input  logic [NUM_SRC-1:0]        src_used_FD,
   input  logic [REG_AW-1:0]         rd_FD,
   input  logic                      regWrite_FD,
   input  logic                      mul_issue_FD,
   input  logic [REG_AW-1:0]         rd_DX,
   input  logic                      regWrite_DX,
   input  logic                      memRead_DX,
   input  logic                      mul_start_DX,
   input  logic [REG_AW-1:0]         rd_XM,
   input  logic                      regWrite_XM,
   input  logic [REG_AW-1:0]         rd_MW,
   input  logic                      regWrite_MW,
   output logic [2*NUM_SRC-1:0]      fwd_sel,
   output logic                      stall_FD,
   output logic                      bubble_DX,
   output logic                      mul_done,
   output logic [REG_AW-1:0]         mul_rd,
   output logic                      mul_err,
   output logic [CNT_W-1:0]          stall_count
);

   localparam int CW = (MUL_LAT > 2) ? $clog2(MUL_LAT) : 1;
   localparam logic [CW-1:0] CNT_LOAD = CW'(MUL_LAT - 1);

   logic          busy;
   logic [CW-1:0] cnt;
   logic          load_use;
   logic          mul_haz;
   logic          mul_stall;

   assign mul_done = !reset && busy && (cnt == '0);

   always_comb begin
      fwd_sel = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         logic [REG_AW-1:0] s;
         s = src_DX[i*REG_AW +: REG_AW];
         if (s == '0)
            fwd_sel[2*i +: 2] = 2'b00;
         else if (mul_done && mul_rd == s)
            fwd_sel[2*i +: 2] = 2'b11;
         else if (regWrite_XM && rd_XM == s)
            fwd_sel[2*i +: 2] = 2'b10;
         else if (regWrite_MW && rd_MW == s)
            fwd_sel[2*i +: 2] = 2'b01;
      end
   end

   always_comb begin
      load_use = 1'b0;
      mul_haz  = mul_issue_FD;
      if (regWrite_FD && rd_FD == mul_rd && rd_FD != '0)
         mul_haz = 1'b1;
      for (int i = 0; i < NUM_SRC; i++) begin
         logic [REG_AW-1:0] s;
         s = src_FD[i*REG_AW +: REG_AW];
         if (src_used_FD[i] && s == rd_DX)
            load_use = 1'b1;
         if (src_used_FD[i] && s == mul_rd && s != '0)
            mul_haz = 1'b1;
      end
      load_use = load_use && memRead_DX && regWrite_DX && (rd_DX != '0);
   end

   // the dependent op is released at cnt==1 so it reaches DX exactly at mul_done
   assign mul_stall = !reset && busy && (cnt > CW'(1)) && mul_haz;
   assign stall_FD  = load_use || mul_stall;
   assign bubble_DX = stall_FD;

   always_ff @(posedge clk) begin
      if (reset) begin
         busy        <= 1'b0;
         cnt         <= '0;
         mul_rd      <= '0;
         mul_err     <= 1'b0;
         stall_count <= '0;
      end else begin
         if (stall_FD && stall_count != '1)
            stall_count <= stall_count + CNT_W'(1);
         if (!busy) begin
            if (mul_start_DX) begin
               busy   <= 1'b1;
               cnt    <= CNT_LOAD;
               mul_rd <= rd_DX;
            end
         end else if (cnt != '0) begin
            cnt <= cnt - CW'(1);
            if (mul_start_DX)
               mul_err <= 1'b1;
         end else if (mul_start_DX) begin
            cnt    <= CNT_LOAD;
            mul_rd <= rd_DX;
         end else begin
            busy <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench for fwd_hazard_unit (MUL_LAT=3, CNT_W=4 for saturation).
module tb_fwd_hazard_unit;

   localparam int REG_AW  = 5;
   localparam int NUM_SRC = 2;
   localparam int MUL_LAT = 3;
   localparam int CNT_W   = 4;

   logic                      clk = 1'b0;
   logic                      reset;
   logic [NUM_SRC*REG_AW-1:0] src_DX;
   logic [NUM_SRC*REG_AW-1:0] src_FD;
   logic [NUM_SRC-1:0]        src_used_FD;
   logic [REG_AW-1:0]         rd_FD;
   logic                      regWrite_FD;
   logic                      mul_issue_FD;
   logic [REG_AW-1:0]         rd_DX;
   logic                      regWrite_DX;
   logic                      memRead_DX;
   logic                      mul_start_DX;
   logic [REG_AW-1:0]         rd_XM;
   logic                      regWrite_XM;
   logic [REG_AW-1:0]         rd_MW;
   logic                      regWrite_MW;
   logic [2*NUM_SRC-1:0]      fwd_sel;
   logic                      stall_FD;
   logic                      bubble_DX;
   logic                      mul_done;
   logic [REG_AW-1:0]         mul_rd;
   logic                      mul_err;
   logic [CNT_W-1:0]          stall_count;

   int checks = 0;
   int errors = 0;

   fwd_hazard_unit #(
      .REG_AW(REG_AW), .NUM_SRC(NUM_SRC),
      .MUL_LAT(MUL_LAT), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .reset(reset),
      .src_DX(src_DX), .src_FD(src_FD),
      .src_used_FD(src_used_FD),
      .rd_FD(rd_FD), .regWrite_FD(regWrite_FD),
      .mul_issue_FD(mul_issue_FD),
      .rd_DX(rd_DX), .regWrite_DX(regWrite_DX),
      .memRead_DX(memRead_DX), .mul_start_DX(mul_start_DX),
      .rd_XM(rd_XM), .regWrite_XM(regWrite_XM),
      .rd_MW(rd_MW), .regWrite_MW(regWrite_MW),
      .fwd_sel(fwd_sel), .stall_FD(stall_FD),
      .bubble_DX(bubble_DX), .mul_done(mul_done),
      .mul_rd(mul_rd), .mul_err(mul_err),
      .stall_count(stall_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic clr();
      src_DX = '0; src_FD = '0; src_used_FD = '0;
      rd_FD = '0; regWrite_FD = 0; mul_issue_FD = 0;
      rd_DX = '0; regWrite_DX = 0; memRead_DX = 0;
      mul_start_DX = 0;
      rd_XM = '0; regWrite_XM = 0;
      rd_MW = '0; regWrite_MW = 0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_load_use();
      memRead_DX = 1; regWrite_DX = 1; rd_DX = 5'd7;
      src_FD = {5'd7, 5'd0}; src_used_FD = 2'b10;
   endtask

   initial begin
      reset = 1;
      clr();
      tick();
      tick();
      reset = 0;
      #1;
      chk("rst_done", 32'(mul_done), 0);
      chk("rst_mul_rd", 32'(mul_rd), 0);
      chk("rst_err", 32'(mul_err), 0);
      chk("rst_cnt", 32'(stall_count), 0);
      chk("rst_fwd", 32'(fwd_sel), 0);

      // forwarding priority
      rd_XM = 5'd3; regWrite_XM = 1;
      rd_MW = 5'd3; regWrite_MW = 1;
      src_DX = {5'd0, 5'd3};
      #1 chk("fwd_xm", 32'(fwd_sel), 32'b0010);
      regWrite_XM = 0;
      #1 chk("fwd_mw", 32'(fwd_sel), 32'b0001);
      src_DX = {5'd3, 5'd3};
      #1 chk("fwd_mw2", 32'(fwd_sel), 32'b0101);

      // register 0 never forwarded
      clr();
      rd_XM = 5'd0; regWrite_XM = 1; src_DX = '0;
      #1 chk("fwd_r0", 32'(fwd_sel), 0);
      chk("r0_stall", 32'(stall_FD), 0);

      // load-use
      clr();
      set_load_use();
      #1 chk("lu_stall", 32'(stall_FD), 1);
      chk("lu_bubble", 32'(bubble_DX), 1);
      tick();
      clr();
      rd_MW = 5'd7; regWrite_MW = 1; src_DX = {5'd7, 5'd0};
      #1 chk("lu_rel", 32'(stall_FD), 0);
      chk("lu_cnt", 32'(stall_count), 1);
      chk("lu_fwd", 32'(fwd_sel), 32'b0100);
      clr();
      set_load_use();
      src_used_FD = 2'b01;
      #1 chk("lu_unused", 32'(stall_FD), 0);
      tick();
      clr();
      #1 chk("lu_cnt2", 32'(stall_count), 1);

      // multiply RAW
      mul_start_DX = 1; rd_DX = 5'd9;
      tick();
      clr();
      src_FD = {5'd0, 5'd9}; src_used_FD = 2'b01;
      #1 chk("raw_stall", 32'(stall_FD), 1);
      chk("raw_bub", 32'(bubble_DX), 1);
      chk("raw_nodone", 32'(mul_done), 0);
      tick();
      #1 chk("raw_rel", 32'(stall_FD), 0);
      chk("raw_nodone1", 32'(mul_done), 0);
      tick();
      clr();
      src_DX = {5'd0, 5'd9};
      rd_XM = 5'd9; regWrite_XM = 1;
      #1 chk("raw_done", 32'(mul_done), 1);
      chk("raw_rd", 32'(mul_rd), 9);
      chk("raw_fwd", 32'(fwd_sel), 32'b0011);
      chk("raw_cnt", 32'(stall_count), 2);

      // back-to-back start on the done cycle
      mul_start_DX = 1; rd_DX = 5'd12;
      tick();
      clr();
      #1 chk("b2b_rd", 32'(mul_rd), 12);
      chk("b2b_nodone", 32'(mul_done), 0);
      regWrite_FD = 1; rd_FD = 5'd12;
      #1 chk("waw_stall", 32'(stall_FD), 1);
      clr();
      mul_issue_FD = 1;
      #1 chk("struct_stall", 32'(stall_FD), 1);
      clr();
      tick();
      mul_issue_FD = 1;
      #1 chk("struct_rel", 32'(stall_FD), 0);
      clr();
      mul_start_DX = 1; rd_DX = 5'd20;
      tick();
      clr();
      #1 chk("err_set", 32'(mul_err), 1);
      chk("err_done", 32'(mul_done), 1);
      chk("err_rd", 32'(mul_rd), 12);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("err_nodone", 32'(mul_done), 0);
      end
      chk("err_sticky", 32'(mul_err), 1);
      chk("cnt_pre_rst", 32'(stall_count), 2);

      // reset mid-op
      mul_start_DX = 1; rd_DX = 5'd5;
      tick();
      clr();
      tick();
      reset = 1;
      set_load_use();
      mul_issue_FD = 1;
      #1 chk("rst_lu", 32'(stall_FD), 1);
      chk("rst_md", 32'(mul_done), 0);
      tick();
      reset = 0;
      clr();
      #1 chk("rst2_cnt", 32'(stall_count), 0);
      chk("rst2_err", 32'(mul_err), 0);
      chk("rst2_rd", 32'(mul_rd), 0);
      for (int i = 0; i < 3; i++) begin
         chk("rst2_done", 32'(mul_done), 0);
         tick();
      end

      // saturation
      set_load_use();
      for (int i = 0; i < 5; i++) tick();
      chk("sat_mid", 32'(stall_count), 5);
      for (int i = 0; i < 15; i++) tick();
      chk("sat_top", 32'(stall_count), 15);
      clr();
      tick();
      chk("sat_hold", 32'(stall_count), 15);

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
